// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: op_type encodings and the hazard controller state enum.
package pipeline_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h3;
    localparam logic [3:0] OP_MULDIV = 4'h9;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count register: clear, saturate at all-ones, otherwise hold or step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, mult/div occupancy.
// Define HAZARD_MULDIV_EN to compile in the multi-cycle mult/div sequencer.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs_addr,
    input  logic [4:0]             id_rt_addr,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [3:0]             ex_op_type,
    input  logic [4:0]             ex_reg_write_addr,
    input  logic                   ex_redirect,
    input  logic                   stall_cnt_clr,
    output logic                   pc_stall,
    output logic                   if2id_stall,
    output logic                   if2id_flush,
    output logic                   id2ex_stall,
    output logic                   id2ex_flush,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic load_use_s;
    logic mult_stall_s;

    assign load_use_s = (ex_op_type == OP_LOAD) && (ex_reg_write_addr != 5'd0) &&
                        ((id_uses_rs && (id_rs_addr == ex_reg_write_addr)) ||
                         (id_uses_rt && (id_rt_addr == ex_reg_write_addr)));

`ifdef HAZARD_MULDIV_EN
    localparam logic [3:0] REMAIN_INIT = 4'(MULDIV_CYCLES - 2);

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] remain_r;
    logic [3:0] remain_next_s;
    logic       start_s;

    // State and remaining-BUSY-cycle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            remain_r <= 4'd0;
        end else begin
            state_r  <= state_next_s;
            remain_r <= remain_next_s;
        end
    end

    // Next state: remain holds the BUSY cycles still to go after the start cycle.
    always_comb begin
        state_next_s  = state_r;
        remain_next_s = remain_r;
        start_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!ex_redirect && (ex_op_type == OP_MULDIV)) begin
                    start_s       = 1'b1;
                    remain_next_s = REMAIN_INIT;
                    state_next_s  = (REMAIN_INIT != 4'd0) ? BUSY : IDLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                remain_next_s = (remain_r != 4'd0) ? (remain_r - 4'd1) : 4'd0;
                if (remain_r <= 4'd1) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s  = IDLE;
                remain_next_s = 4'd0;
            end
        endcase
    end

    assign muldiv_busy  = (state_r == BUSY);
    assign mult_stall_s = start_s || (state_r == BUSY);
`else
    assign muldiv_busy  = 1'b0;
    assign mult_stall_s = 1'b0;
`endif

    // Output priority: redirect flush, then mult/div occupancy, then load-use.
    always_comb begin
        pc_stall    = 1'b0;
        if2id_stall = 1'b0;
        id2ex_stall = 1'b0;
        if2id_flush = 1'b0;
        id2ex_flush = 1'b0;
        if (ex_redirect) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (mult_stall_s || load_use_s) begin
            pc_stall    = 1'b1;
            if2id_stall = 1'b1;
            id2ex_stall = 1'b1;
        end else begin
            pc_stall    = 1'b0;
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall),
        .clr   (stall_cnt_clr),
        .count (stall_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cases plus randomized traffic vs a cycle-level model.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int MC   = 4;
    localparam int W    = 4;
    localparam int CMAX = (1 << W) - 1;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   id_rs_addr = 5'd0, id_rt_addr = 5'd0, ex_reg_write_addr = 5'd0;
    logic         id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_redirect = 1'b0, stall_cnt_clr = 1'b0;
    logic [3:0]   ex_op_type = 4'h0;
    logic         pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, muldiv_busy;
    logic [W-1:0] stall_count;

    typedef struct {
        bit stall;
        bit flush;
        bit busy;
        int count;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   occ   = 0;   // stall cycles of the mult/div occupancy still owed after this one
    int   cnt   = 0;

    hazard_ctrl #(.MULDIV_CYCLES(MC), .STALL_CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_op_type(ex_op_type), .ex_reg_write_addr(ex_reg_write_addr),
        .ex_redirect(ex_redirect), .stall_cnt_clr(stall_cnt_clr),
        .pc_stall(pc_stall), .if2id_stall(if2id_stall), .if2id_flush(if2id_flush),
        .id2ex_stall(id2ex_stall), .id2ex_flush(id2ex_flush),
        .muldiv_busy(muldiv_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's expected response.
    task automatic step(input bit urs, input bit urt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [3:0] op, input logic [4:0] wa, input bit redir,
                        input bit clr, input bit rstv);
        exp_t e;
        int   occ_n;
        @(posedge clk);
        #1;
        id_uses_rs = urs; id_uses_rt = urt; id_rs_addr = rs; id_rt_addr = rt;
        ex_op_type = op; ex_reg_write_addr = wa; ex_redirect = redir;
        stall_cnt_clr = clr; rst_n = rstv;
        if (!rstv) begin
            occ = 0;
            cnt = 0;
        end
        e.stall = 1'b0; e.flush = 1'b0; e.busy = 1'b0; e.count = cnt;
        occ_n = occ;
        if (occ > 0) begin
            e.stall = 1'b1;
            e.busy  = 1'b1;
            occ_n   = occ - 1;
        end else if (redir) begin
            e.flush = 1'b1;
        end else if (MD_EN && op == OP_MULDIV) begin
            e.stall = 1'b1;
            occ_n   = MC - 2;
        end else if (op == OP_LOAD && wa != 0 && ((urs && rs == wa) || (urt && rt == wa))) begin
            e.stall = 1'b1;
        end
        q.push_back(e);
        if (rstv) begin
            occ = occ_n;
            if (clr) cnt = 0;
            else if (e.stall && cnt < CMAX) cnt = cnt + 1;
        end
    endtask

    task automatic idle(input bit rstv);
        step(1'b0, 1'b0, 5'd0, 5'd0, OP_NOP, 5'd0, 1'b0, 1'b0, rstv);
    endtask

    // Monitor: compare the DUT against the oldest expectation away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_stall",    int'(pc_stall),    int'(e.stall));
            chk("if2id_stall", int'(if2id_stall), int'(e.stall));
            chk("id2ex_stall", int'(id2ex_stall), int'(e.stall));
            chk("if2id_flush", int'(if2id_flush), int'(e.flush));
            chk("id2ex_flush", int'(id2ex_flush), int'(e.flush));
            chk("muldiv_busy", int'(muldiv_busy), int'(e.busy));
            chk("stall_count", int'(stall_count), e.count);
        end
    end

    initial begin
        logic [3:0] op;
        bit         rd;
        idle(1'b0);
        idle(1'b1);
        // load-use on rs, then $0 destination, then rt match, then back-to-back
        step(1'b1, 1'b0, 5'd8, 5'd0, OP_LOAD, 5'd8, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b1, 5'd0, 5'd0, OP_LOAD, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd3, 5'd9, OP_LOAD, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd3, 5'd9, OP_LOAD, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd9, 5'd9, OP_LOAD, 5'd9, 1'b0, 1'b0, 1'b1);
        // redirect beats load-use
        step(1'b1, 1'b0, 5'd8, 5'd0, OP_LOAD, 5'd8, 1'b1, 1'b1, 1'b1);
        // mult/div occupancy, then NOP bubbles
        step(1'b0, 1'b0, 5'd1, 5'd2, OP_MULDIV, 5'd4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        // reset at the second BUSY cycle
        step(1'b0, 1'b0, 5'd1, 5'd2, OP_MULDIV, 5'd4, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        // saturation: 20 stall cycles, then clear
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 5'd5, 5'd0, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, OP_NOP, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        // randomized traffic; bubbles and no redirect while the mult/div occupies EX
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_LOAD;
                1:       op = OP_MULDIV;
                2:       op = OP_NOP;
                default: op = 4'($urandom_range(0, 15));
            endcase
            rd = ($urandom_range(0, 5) == 0);
            if (occ > 0) begin
                op = OP_NOP;
                rd = 1'b0;
            end
            step(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 op, 5'($urandom_range(0, 3)), rd, ($urandom_range(0, 19) == 0), 1'b1);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
